// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo pulse generator fed by the PID stage.
// The duty request is clamped to MIN_DUTY..MAX_DUTY and latched only on frame
// load edges, so a frame never holds a torn or truncated pulse.
// Optional build macro: SERVO_PWM_SLEW_LIMIT_EN. When it is defined, each
// frame moves the latched duty toward the clamped request by at most SLEW_STEP.
module servo_pwm_gen #(
  parameter int PERIOD      = 1000000,
  parameter int MIN_DUTY    = 50000,
  parameter int CENTER_DUTY = 75000,
  parameter int MAX_DUTY    = 100000,
  parameter int SLEW_STEP   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] duty_in,
  output logic        pwm_out,
  output logic        period_start,
  output logic [17:0] duty_active,
  output logic        running
);

  localparam int          CNT_W  = 20;
  localparam logic [17:0] MIN_D  = 18'(MIN_DUTY);
  localparam logic [17:0] MAX_D  = 18'(MAX_DUTY);
  localparam logic [17:0] CTR_D  = 18'(CENTER_DUTY);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  // Reject parameter sets that would break the frame or clamp arithmetic.
  generate
    if (PERIOD >= (1 << CNT_W) || PERIOD <= MAX_DUTY) begin : g_bad_period
      $error("servo_pwm_gen: PERIOD must be < 2^20 and > MAX_DUTY");
    end
    if (MIN_DUTY < 1 || MIN_DUTY > CENTER_DUTY || CENTER_DUTY > MAX_DUTY ||
        MAX_DUTY >= (1 << 18)) begin : g_bad_duty
      $error("servo_pwm_gen: need 1 <= MIN_DUTY <= CENTER_DUTY <= MAX_DUTY < 2^18");
    end
    if (SLEW_STEP < 1 || SLEW_STEP >= (1 << 18)) begin : g_bad_slew
      $error("servo_pwm_gen: SLEW_STEP must be in 1..2^18-1");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [17:0]      duty_q;
  logic             pwm_q;
  logic             ps_q;
  logic             run_q;

  logic [17:0]      target_d;
  logic [17:0]      next_duty_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             pwm_cont_d;

  // Clamp the raw request into the servo's mechanical range.
  always_comb begin
    target_d = duty_in;
    if (duty_in < MIN_D)      target_d = MIN_D;
    else if (duty_in > MAX_D) target_d = MAX_D;
  end

`ifdef SERVO_PWM_SLEW_LIMIT_EN
  localparam logic [17:0] STEP_D = 18'(SLEW_STEP);
  logic [17:0] dist_d;

  // Step the latched duty toward the target; land exactly when within one step.
  // Both endpoints are already in range, so the result is too.
  always_comb begin
    dist_d      = '0;
    next_duty_d = target_d;
    if (target_d > duty_q) begin
      dist_d = target_d - duty_q;
      if (dist_d > STEP_D) next_duty_d = duty_q + STEP_D;
    end else begin
      dist_d = duty_q - target_d;
      if (dist_d > STEP_D) next_duty_d = duty_q - STEP_D;
    end
  end
`else
  // Without slew limiting the clamped request is loaded directly.
  always_comb begin
    next_duty_d = target_d;
  end
`endif

  // Next in-frame count and the pulse level that goes with it.
  always_comb begin
    cnt_inc_d  = cnt_q + CNT_W'(1);
    pwm_cont_d = (cnt_inc_d < {{(CNT_W-18){1'b0}}, duty_q});
  end

  // Frame FSM: all outputs registered so pwm_out is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      duty_q  <= CTR_D;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (en) begin
            state_q <= S_RUN;
            duty_q  <= next_duty_d;
            pwm_q   <= 1'b1;
            ps_q    <= 1'b1;
            run_q   <= 1'b1;
          end else begin
            pwm_q <= 1'b0;
            ps_q  <= 1'b0;
            run_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (en) begin
              duty_q <= next_duty_d;
              pwm_q  <= 1'b1;
              ps_q   <= 1'b1;
            end else begin
              // duty_active is held across the park.
              state_q <= S_IDLE;
              pwm_q   <= 1'b0;
              ps_q    <= 1'b0;
              run_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc_d;
            pwm_q <= pwm_cont_d;
            ps_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          pwm_q   <= 1'b0;
          ps_q    <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;
  assign running      = run_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen on a scaled-down frame (PERIOD=100,
// duty range 20..40, center 30, slew step 3) so every frame is cheap.
module tb_servo_pwm_gen;

  localparam int P  = 100;
  localparam int MN = 20;
  localparam int CT = 30;
  localparam int MX = 40;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [17:0] duty_in = '0;
  logic        pwm_out;
  logic        period_start;
  logic [17:0] duty_active;
  logic        running;

  int checks   = 0;
  int failures = 0;

  servo_pwm_gen #(
    .PERIOD(P), .MIN_DUTY(MN), .CENTER_DUTY(CT), .MAX_DUTY(MX), .SLEW_STEP(ST)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_start(period_start),
    .duty_active(duty_active), .running(running)
  );

  always #5 clk = ~clk;

  // Advance one edge and land at a sample point away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting on a period_start cycle, walk one frame. Applies a duty/en change
  // at in-frame cycle chg_at. Reports high cycles, frame length, whether the
  // next frame started, and high cycles that were not contiguous from cycle 0.
  task automatic run_frame(input int chg_at, input logic [17:0] nd, input logic ne,
                           output int hi, output int len, output logic nxt,
                           output int glitch);
    logic was_low;
    hi = 0; len = 0; glitch = 0; was_low = 1'b0;
    do begin
      if (len == chg_at) begin duty_in = nd; en = ne; end
      if (pwm_out) begin
        hi++;
        if (was_low) glitch++;
      end else begin
        was_low = 1'b1;
      end
      len++;
      tick();
    end while (!period_start && running && len < 10 * P);
    nxt = period_start;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; duty_in = 18'd90000;
    #2;
    tick(); tick(); tick();
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got %0d exp 0", pwm_out); end
    checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps got %0d exp 0", period_start); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got %0d exp 0", running); end
    checks++; if (duty_active !== 18'(CT)) begin failures++; $display("FAIL reset_duty got %0d exp %0d", duty_active, CT); end
  endtask

  task automatic test_nominal();
    int hi, len, gl; logic nxt;
    duty_in = 18'(CT);
    rst = 1'b0;
    tick();
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL nom_first_ps got %0d exp 1", period_start); end
    checks++; if (pwm_out !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL nom_first_pwm_run got %0d/%0d exp 1/1", pwm_out, running); end
    checks++; if (duty_active !== 18'(CT)) begin failures++; $display("FAIL nom_duty got %0d exp %0d", duty_active, CT); end
    run_frame(-1, 18'(CT), 1'b1, hi, len, nxt, gl);
    checks++; if (hi != CT) begin failures++; $display("FAIL nom_high got %0d exp %0d", hi, CT); end
    checks++; if (len != P) begin failures++; $display("FAIL nom_len got %0d exp %0d", len, P); end
    checks++; if (nxt !== 1'b1) begin failures++; $display("FAIL nom_next_ps got %0d exp 1", nxt); end
    checks++; if (gl != 0) begin failures++; $display("FAIL nom_glitch got %0d exp 0", gl); end
  endtask

  // Each frame: duty latched at its start, request changed mid-frame.
  task automatic test_clamp();
    int hi, len, gl; logic nxt;
    int          exp_d [6] = '{CT, MX, MN, MX, MN, 33};
    logic [17:0] req   [6] = '{18'd120, 18'd10, 18'(MX), 18'(MN), 18'd33, 18'd33};
    int          at    [6] = '{30, 5, 0, 50, 99, 10};
    for (int f = 0; f < 6; f++) begin
      checks++; if (duty_active !== 18'(exp_d[f])) begin failures++; $display("FAIL clamp_duty%0d got %0d exp %0d", f, duty_active, exp_d[f]); end
      run_frame(at[f], req[f], 1'b1, hi, len, nxt, gl);
      checks++; if (hi != exp_d[f] || len != P || gl != 0 || nxt !== 1'b1) begin
        failures++; $display("FAIL clamp_frame%0d got hi=%0d len=%0d gl=%0d nxt=%0d exp hi=%0d len=%0d gl=0 nxt=1", f, hi, len, gl, nxt, exp_d[f], P);
      end
    end
  endtask

  task automatic test_disable();
    int hi, len, gl, ps_cnt, pwm_cnt; logic nxt;
    run_frame(40, 18'd25, 1'b0, hi, len, nxt, gl);
    checks++; if (hi != 33 || len != P || nxt !== 1'b0) begin failures++; $display("FAIL dis_frame got hi=%0d len=%0d nxt=%0d exp hi=33 len=%0d nxt=0", hi, len, nxt, P); end
    checks++; if (running !== 1'b0 || pwm_out !== 1'b0) begin failures++; $display("FAIL dis_idle got run=%0d pwm=%0d exp 0/0", running, pwm_out); end
    ps_cnt = 0; pwm_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      if (period_start) ps_cnt++;
      if (pwm_out) pwm_cnt++;
      tick();
    end
    checks++; if (ps_cnt != 0 || pwm_cnt != 0) begin failures++; $display("FAIL dis_quiet got ps=%0d pwm=%0d exp 0/0", ps_cnt, pwm_cnt); end
    checks++; if (duty_active !== 18'd33) begin failures++; $display("FAIL dis_duty_held got %0d exp 33", duty_active); end
  endtask

  task automatic test_reset_midpulse();
    int hi, len, gl; logic nxt;
    duty_in = 18'd33; en = 1'b1;
    tick();
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL rmp_start got %0d exp 1", period_start); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL rmp_pre_pwm got %0d exp 1", pwm_out); end
    #1 rst = 1'b1;
    #1;
    checks++; if (pwm_out !== 1'b0 || running !== 1'b0 || period_start !== 1'b0) begin
      failures++; $display("FAIL rmp_async got pwm=%0d run=%0d ps=%0d exp 0/0/0", pwm_out, running, period_start);
    end
    checks++; if (duty_active !== 18'(CT)) begin failures++; $display("FAIL rmp_duty got %0d exp %0d", duty_active, CT); end
    duty_in = 18'd15;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (period_start !== 1'b1 || duty_active !== 18'(MN)) begin
      failures++; $display("FAIL rmp_restart got ps=%0d duty=%0d exp 1/%0d", period_start, duty_active, MN);
    end
    run_frame(-1, 18'd15, 1'b1, hi, len, nxt, gl);
    checks++; if (hi != MN || len != P) begin failures++; $display("FAIL rmp_frame got hi=%0d len=%0d exp %0d/%0d", hi, len, MN, P); end
  endtask

`ifdef SERVO_PWM_SLEW_LIMIT_EN
  task automatic test_slew();
    int hi, len, gl; logic nxt;
    int exp_d [6] = '{33, 36, 39, 40, 40, 40};
    duty_in = 18'(MX);
    rst = 1'b0;
    tick();
    for (int f = 0; f < 6; f++) begin
      checks++; if (duty_active !== 18'(exp_d[f])) begin failures++; $display("FAIL slew_duty%0d got %0d exp %0d", f, duty_active, exp_d[f]); end
      run_frame(-1, 18'(MX), 1'b1, hi, len, nxt, gl);
      checks++; if (hi != exp_d[f] || len != P) begin failures++; $display("FAIL slew_frame%0d got hi=%0d len=%0d exp %0d/%0d", f, hi, len, exp_d[f], P); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SERVO_PWM_SLEW_LIMIT_EN
    test_slew();
`else
    test_nominal();
    test_clamp();
    test_disable();
    test_reset_midpulse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
